thread_registers: RTL and testbench

//  Per-thread register file: 16 x DATA_BITS registers; direct upstream feeder of the thread ALU.

---
 rtl/gpu_pkg.sv | 27 ++
 rtl/thread_registers.sv | 103 ++++++++++
 tb/tb_thread_registers.sv | 128 ++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared core-state, writeback-mux and special-register encodings
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'b000,
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        REQUEST = 3'b011,
        WAIT    = 3'b100,
        EXECUTE = 3'b101,
        UPDATE  = 3'b110,
        DONE    = 3'b111
    } core_state_t;

    typedef enum logic [1:0] {
        ARITHMETIC = 2'b00,
        MEMORY     = 2'b01,
        CONSTANT   = 2'b10,
        RESERVED   = 2'b11
    } reg_input_mux_t;

    localparam logic [3:0] R_BLOCK_IDX  = 4'd13;
    localparam logic [3:0] R_BLOCK_DIM  = 4'd14;
    localparam logic [3:0] R_THREAD_IDX = 4'd15;
    localparam int         GP_REGS      = 13;

endpackage

// File: rtl/thread_registers.sv
// thread_registers: per-thread 16-entry register file with read-only R13-R15 specials; THREAD_REGS_PARITY_EN adds even-parity storage and a sticky parity_error output
module thread_registers
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int THREAD_ID         = 0,
    parameter int DATA_BITS         = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [7:0]           block_id,
    input  logic [2:0]           core_state,
    input  logic [3:0]           decoded_rd_address,
    input  logic [3:0]           decoded_rs_address,
    input  logic [3:0]           decoded_rt_address,
    input  logic                 decoded_reg_write_enable,
    input  logic [1:0]           decoded_reg_input_mux,
    input  logic [7:0]           decoded_immediate,
    input  logic [DATA_BITS-1:0] alu_out,
    input  logic [DATA_BITS-1:0] lsu_out,
    output logic [DATA_BITS-1:0] rs,
    output logic [DATA_BITS-1:0] rt
`ifdef THREAD_REGS_PARITY_EN
    ,
    output logic                 parity_error
`endif
);

    logic [DATA_BITS-1:0] regs [GP_REGS];
    logic [7:0]           block_idx;
    logic [DATA_BITS-1:0] wb_data;
    logic [DATA_BITS-1:0] rs_data;
    logic [DATA_BITS-1:0] rt_data;
    logic                 wb_en;
`ifdef THREAD_REGS_PARITY_EN
    logic                 par [GP_REGS];
    logic                 par_bad;
`endif

    // writeback source select; reserved mux code and special targets suppress the write
    always_comb begin
        wb_data = decoded_reg_input_mux == ARITHMETIC ? alu_out :
                  decoded_reg_input_mux == MEMORY     ? lsu_out :
                  DATA_BITS'(decoded_immediate);
        wb_en   = core_state == UPDATE && decoded_reg_write_enable &&
                  decoded_rd_address < R_BLOCK_IDX && decoded_reg_input_mux != RESERVED;
    end

    // operand read mux, specials decoded ahead of the general registers
    always_comb begin
        rs_data = decoded_rs_address == R_BLOCK_IDX  ? DATA_BITS'(block_idx) :
                  decoded_rs_address == R_BLOCK_DIM  ? DATA_BITS'(THREADS_PER_BLOCK) :
                  decoded_rs_address == R_THREAD_IDX ? DATA_BITS'(THREAD_ID) :
                  regs[decoded_rs_address];
        rt_data = decoded_rt_address == R_BLOCK_IDX  ? DATA_BITS'(block_idx) :
                  decoded_rt_address == R_BLOCK_DIM  ? DATA_BITS'(THREADS_PER_BLOCK) :
                  decoded_rt_address == R_THREAD_IDX ? DATA_BITS'(THREAD_ID) :
                  regs[decoded_rt_address];
    end

`ifdef THREAD_REGS_PARITY_EN
    // stored parity must make data plus parity bit even; specials are never checked
    always_comb begin
        par_bad = (decoded_rs_address < R_BLOCK_IDX && ((^regs[decoded_rs_address]) ^ par[decoded_rs_address])) ||
                  (decoded_rt_address < R_BLOCK_IDX && ((^regs[decoded_rt_address]) ^ par[decoded_rt_address]));
    end
`endif

    // register file state: reset dominates, disabled threads freeze everything
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < GP_REGS; i++) begin
                regs[i] <= '0;
`ifdef THREAD_REGS_PARITY_EN
                par[i]  <= 1'b0;
`endif
            end
            block_idx <= '0;
            rs        <= '0;
            rt        <= '0;
`ifdef THREAD_REGS_PARITY_EN
            parity_error <= 1'b0;
`endif
        end else if (enable) begin
            block_idx <= block_id;
            if (core_state == REQUEST) begin
                rs <= rs_data;
                rt <= rt_data;
`ifdef THREAD_REGS_PARITY_EN
                if (par_bad) parity_error <= 1'b1;
`endif
            end
            if (wb_en) begin
                regs[decoded_rd_address] <= wb_data;
`ifdef THREAD_REGS_PARITY_EN
                par[decoded_rd_address]  <= ^wb_data;
`endif
            end
        end
    end

endmodule

// File: tb/tb_thread_registers.sv
// tb_thread_registers: randomized check of thread_registers against an array model; THREAD_REGS_PARITY_EN also checks parity_error stays clear
module tb_thread_registers;

    localparam int TPB = 4;
    localparam int TID = 2;
    localparam int DB  = 8;
    localparam logic [2:0] REQ = 3'b011;
    localparam logic [2:0] UPD = 3'b110;

    logic          clk = 1'b0;
    logic          reset, enable;
    logic [7:0]    block_id;
    logic [2:0]    core_state;
    logic [3:0]    rd_a, rs_a, rt_a;
    logic          we;
    logic [1:0]    mux;
    logic [7:0]    imm;
    logic [DB-1:0] alu, lsu, rs, rt;
`ifdef THREAD_REGS_PARITY_EN
    logic          parity_error;
`endif

    int tests = 0;
    int fails = 0;
    int mreg [16];
    int mrs, mrt;

    always #5 clk = ~clk;

    thread_registers #(.THREADS_PER_BLOCK(TPB), .THREAD_ID(TID), .DATA_BITS(DB)) dut (
        .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
        .core_state(core_state), .decoded_rd_address(rd_a),
        .decoded_rs_address(rs_a), .decoded_rt_address(rt_a),
        .decoded_reg_write_enable(we), .decoded_reg_input_mux(mux),
        .decoded_immediate(imm), .alu_out(alu), .lsu_out(lsu),
        .rs(rs), .rt(rt)
`ifdef THREAD_REGS_PARITY_EN
        , .parity_error(parity_error)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mread(input int a);
        return a == 13 ? mreg[13] : a == 14 ? TPB : a == 15 ? TID : mreg[a];
    endfunction

    task automatic step(input logic r, input logic e, input logic [2:0] st,
                        input logic [3:0] d, input logic [3:0] s, input logic [3:0] t,
                        input logic w, input logic [1:0] m, input logic [7:0] im,
                        input logic [7:0] al, input logic [7:0] ls, input logic [7:0] bk);
        @(negedge clk);
        reset = r; enable = e; core_state = st; rd_a = d; rs_a = s; rt_a = t;
        we = w; mux = m; imm = im; alu = al; lsu = ls; block_id = bk;
        @(posedge clk);
        if (r) begin
            mreg = '{default: 0};
            mrs = 0;
            mrt = 0;
        end else if (e) begin
            if (st == REQ) begin
                mrs = mread(int'(s));
                mrt = mread(int'(t));
            end
            if (st == UPD && w && d < 13 && m != 2'b11)
                mreg[d] = m == 2'b00 ? int'(al) : m == 2'b01 ? int'(ls) : int'(im);
            mreg[13] = int'(bk);
        end
        #1;
        check("rs_model", 32'(rs), 32'(mrs));
        check("rt_model", 32'(rt), 32'(mrt));
`ifdef THREAD_REGS_PARITY_EN
        check("parity_error", 32'(parity_error), 32'd0);
`endif
    endtask

    initial begin
        step(1, 1, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("reset_rs", 32'(rs), 32'h0);
        check("reset_rt", 32'(rt), 32'h0);
        step(0, 1, REQ, 0, 14, 15, 0, 0, 0, 0, 0, 0);
        check("block_dim", 32'(rs), 32'd4);
        check("thread_idx", 32'(rt), 32'd2);
        step(0, 1, UPD, 3, 0, 0, 1, 2'b10, 8'h5A, 8'h11, 8'h22, 0);
        step(0, 1, REQ, 0, 3, 0, 0, 0, 0, 0, 0, 0);
        check("imm_write", 32'(rs), 32'h5A);
        check("r0_zero", 32'(rt), 32'h0);
        step(0, 1, UPD, 14, 0, 0, 1, 2'b00, 0, 8'hFF, 0, 0);
        step(0, 1, REQ, 0, 14, 3, 0, 0, 0, 0, 0, 0);
        check("special_ro", 32'(rs), 32'd4);
        check("r3_kept", 32'(rt), 32'h5A);
        step(0, 0, 3'd0, 0, 13, 0, 0, 0, 0, 0, 0, 8'd7);
        step(0, 1, REQ, 0, 13, 0, 0, 0, 0, 0, 0, 8'd7);
        check("blk_disabled", 32'(rs), 32'd0);
        step(0, 1, REQ, 0, 13, 0, 0, 0, 0, 0, 0, 8'd7);
        check("blk_loaded", 32'(rs), 32'd7);
        step(0, 0, REQ, 0, 3, 14, 0, 0, 0, 0, 0, 8'd7);
        check("hold_rs", 32'(rs), 32'd7);
        check("hold_rt", 32'(rt), 32'd0);
        step(0, 1, UPD, 3, 0, 0, 1, 2'b11, 8'h01, 8'h02, 8'h03, 8'd7);
        step(0, 1, UPD, 12, 0, 0, 1, 2'b01, 8'h01, 8'h02, 8'hC3, 8'd7);
        step(0, 1, REQ, 0, 3, 12, 0, 0, 0, 0, 0, 8'd7);
        check("mux_reserved", 32'(rs), 32'h5A);
        check("lsu_write", 32'(rt), 32'hC3);
        step(1, 1, UPD, 3, 0, 0, 1, 2'b00, 0, 8'h99, 0, 8'd7);
        step(0, 1, REQ, 0, 3, 14, 0, 0, 0, 0, 0, 8'd7);
        check("reset_mid", 32'(rs), 32'h0);
        check("reset_dim", 32'(rt), 32'd4);
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] st;
            int sel;
            sel = $urandom_range(0, 9);
            st = sel < 4 ? REQ : sel < 8 ? UPD : 3'($urandom_range(0, 7));
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, st,
                 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 3) != 0,
                 2'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
